// File: rtl/cordic_if.sv
// Sample-stream bundle for the pipelined CORDIC: enable, input vector/phase and rotated output.
interface cordic_if #(
    parameter int unsigned PW = 12,
    parameter int unsigned IW = 31,
    parameter int unsigned OW = 32
);
    logic                 enable;
    logic signed [IW-1:0] i_xval;
    logic signed [IW-1:0] i_yval;
    logic        [PW-1:0] i_phase;
    logic signed [OW-1:0] o_xval;
    logic signed [OW-1:0] o_yval;

    modport master (output enable, i_xval, i_yval, i_phase, input o_xval, o_yval);
    modport slave  (input enable, i_xval, i_yval, i_phase, output o_xval, o_yval);
endinterface

// File: rtl/cordic.sv
// Fully pipelined rotation-mode CORDIC: rotates (i_xval, i_yval) by i_phase (fraction of a turn).
// Define CORDIC_GAIN_COMP_EN to add a registered 1/K_N gain-compensation stage (+1 cycle latency).
module cordic #(
    parameter int unsigned PW      = 12,
    parameter int unsigned IW      = 31,
    parameter int unsigned OW      = 32,
    parameter int unsigned NSTAGES = 11
) (
    input  logic    clk,
    input  logic    reset_n,
    cordic_if.slave bus
);
    localparam int unsigned WW = OW + 2;
    localparam int unsigned PA = PW + 4;
    localparam int unsigned GW = WW - OW;

    // atan(2^-k) as a fraction of a turn, tabulated at 2^16 counts/turn and rescaled to PA bits
    function automatic logic [PA-1:0] atan_step(input int unsigned k);
        logic [31:0] a16;
        logic [31:0] a;
        unique case (k)
            0:       a16 = 32'd8192;
            1:       a16 = 32'd4836;
            2:       a16 = 32'd2555;
            3:       a16 = 32'd1297;
            4:       a16 = 32'd651;
            5:       a16 = 32'd326;
            6:       a16 = 32'd163;
            7:       a16 = 32'd81;
            8:       a16 = 32'd41;
            9:       a16 = 32'd20;
            10:      a16 = 32'd10;
            11:      a16 = 32'd5;
            12:      a16 = 32'd3;
            13:      a16 = 32'd1;
            14:      a16 = 32'd1;
            default: a16 = 32'd0;
        endcase
        if (PA >= 16) a = a16 << (PA - 16);
        else          a = (a16 + (32'd1 << (15 - PA))) >> (16 - PA);
        return PA'(a);
    endfunction

    // Drop the guard bits with round-half-to-even
    function automatic logic signed [OW-1:0] round_even(input logic signed [WW-1:0] v);
        logic signed [OW-1:0] t;
        logic        [GW-1:0] f;
        logic                 up;
        t  = v[WW-1:GW];
        f  = v[GW-1:0];
        up = f[GW-1] && ((f[GW-2:0] != '0) || t[0]);
        return t + OW'(up);
    endfunction

    logic signed [WW-1:0] x_in, y_in, x_pre, y_pre;
    logic        [PA-1:0] ph_ext, z_pre;
    logic        [1:0]    quad;

    logic signed [WW-1:0] xs [0:NSTAGES];
    logic signed [WW-1:0] ys [0:NSTAGES];
    logic        [PA-1:0] zs [0:NSTAGES];
    logic signed [OW-1:0] rx, ry;

    // Quadrant pre-rotation leaves a residual angle in [-1/8, +1/8) turn
    always_comb begin
        x_in   = {{(WW-IW-GW){bus.i_xval[IW-1]}}, bus.i_xval, {GW{1'b0}}};
        y_in   = {{(WW-IW-GW){bus.i_yval[IW-1]}}, bus.i_yval, {GW{1'b0}}};
        ph_ext = {bus.i_phase, {(PA-PW){1'b0}}};
        quad   = 2'((4'(bus.i_phase[PW-1 -: 3]) + 4'd1) >> 1);
        z_pre  = ph_ext - {quad, {(PA-2){1'b0}}};
        x_pre  = x_in;
        y_pre  = y_in;
        unique case (quad)
            2'd0: begin x_pre = x_in;  y_pre = y_in;  end
            2'd1: begin x_pre = -y_in; y_pre = x_in;  end
            2'd2: begin x_pre = -x_in; y_pre = -y_in; end
            2'd3: begin x_pre = y_in;  y_pre = -x_in; end
        endcase
    end

    // Pre-rotation register, micro-rotation stages and rounded output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k <= int'(NSTAGES); k++) begin
                xs[k] <= '0;
                ys[k] <= '0;
                zs[k] <= '0;
            end
            rx <= '0;
            ry <= '0;
        end else if (bus.enable) begin
            xs[0] <= x_pre;
            ys[0] <= y_pre;
            zs[0] <= z_pre;
            for (int k = 0; k < int'(NSTAGES); k++) begin
                if (!zs[k][PA-1]) begin
                    xs[k+1] <= xs[k] - (ys[k] >>> k);
                    ys[k+1] <= ys[k] + (xs[k] >>> k);
                    zs[k+1] <= zs[k] - atan_step(unsigned'(k));
                end else begin
                    xs[k+1] <= xs[k] + (ys[k] >>> k);
                    ys[k+1] <= ys[k] - (xs[k] >>> k);
                    zs[k+1] <= zs[k] + atan_step(unsigned'(k));
                end
            end
            rx <= round_even(xs[NSTAGES]);
            ry <= round_even(ys[NSTAGES]);
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    function automatic real inv_gain();
        real g;
        g = 1.0;
        for (int i = 0; i < int'(NSTAGES); i++) g = g * $sqrt(1.0 + 2.0 ** (-2.0 * i));
        return 1.0 / g;
    endfunction

    localparam logic signed [2*OW:0] GCOMP = (2*OW+1)'(longint'(inv_gain() * (2.0 ** (OW - 1))));
    localparam logic signed [2*OW:0] HALF  = (2*OW+1)'(1) <<< (OW - 2);

    logic signed [2*OW:0] px, py;
    logic signed [OW-1:0] gx, gy;

    always_comb begin
        px = (2*OW+1)'(rx) * GCOMP;
        py = (2*OW+1)'(ry) * GCOMP;
    end

    // Scale by round(2^(OW-1)/K_N) / 2^(OW-1) so output magnitude matches input magnitude
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gx <= '0;
            gy <= '0;
        end else if (bus.enable) begin
            gx <= OW'((px + HALF) >>> (OW - 1));
            gy <= OW'((py + HALF) >>> (OW - 1));
        end
    end

    assign bus.o_xval = gx;
    assign bus.o_yval = gy;
`else
    assign bus.o_xval = rx;
    assign bus.o_yval = ry;
`endif
endmodule

// File: tb/tb_cordic.sv
// Directed-vector bench for cordic: table of rotations, phase sweep, latency, enable-hold and reset cases.
module tb_cordic;
    localparam longint FS   = 64'sd1768195000;
    localparam longint H    = 64'sd1250303000;
    localparam longint TOL  = 64'sd2000000;
    localparam longint STOL = 64'sd2652292;
    localparam real    FS_R = 1.6467602581 * 1073741823.0;
    localparam real    PI   = 3.14159265358979;
    localparam int     LAT  = 13;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    cordic_if #(.PW(12), .IW(31), .OW(32)) bus ();
    cordic #(.PW(12), .IW(31), .OW(32), .NSTAGES(11)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] phase;
        longint      xin;
        longint      yin;
        longint      ex;
        longint      ey;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp, input longint tol);
        checks++;
        if (act > exp + tol || act < exp - tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (+/- %0d)", name, act, exp, tol);
        end
    endtask

    task automatic apply(input longint x, input longint y, input logic [11:0] p);
        bus.i_xval  = 31'(x);
        bus.i_yval  = 31'(y);
        bus.i_phase = p;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t   tbl [10];
        longint a;
        longint mn;
        int     n;
        logic [11:0] ph;

        a  = 64'sd1073741823;
        mn = -64'sd1073741824;
        tbl[0] = '{12'h000, a,  0, FS,  0};
        tbl[1] = '{12'h400, a,  0, 0,   FS};
        tbl[2] = '{12'h800, a,  0, -FS, 0};
        tbl[3] = '{12'hC00, a,  0, 0,   -FS};
        tbl[4] = '{12'h200, a,  0, H,   H};
        tbl[5] = '{12'h000, 0,  a, 0,   FS};
        tbl[6] = '{12'h800, mn, 0, FS,  0};
        tbl[7] = '{12'h000, mn, 0, -FS, 0};
        tbl[8] = '{12'hE00, a,  0, H,   -H};
        tbl[9] = '{12'h600, a,  0, -H,  H};

        reset_n    = 1'b0;
        bus.enable = 1'b0;
        apply(0, 0, 12'h000);
        #1;
        check("reset_x", longint'(bus.o_xval), 0, 0);
        check("reset_y", longint'(bus.o_yval), 0, 0);
        step(3);
        reset_n    = 1'b1;
        bus.enable = 1'b1;

        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].xin, tbl[i].yin, tbl[i].phase);
            step(15);
            check($sformatf("vec%0d_x", i), longint'(bus.o_xval), tbl[i].ex, TOL);
            check($sformatf("vec%0d_y", i), longint'(bus.o_yval), tbl[i].ey, TOL);
        end

        // Streamed sweep through a full turn and across the wrap back to 0
        n = 4096 + 16;
        for (int i = 0; i < n + LAT - 1; i++) begin
            if (i < n) apply(a, 0, 12'(i));
            step(1);
            if (i >= LAT - 1) begin
                ph = 12'(i - (LAT - 1));
                check($sformatf("sweep_y_%03h", ph), longint'(bus.o_yval),
                      longint'(FS_R * $sin(2.0 * PI * real'(ph) / 4096.0)), STOL);
                check($sformatf("sweep_x_%03h", ph), longint'(bus.o_xval),
                      longint'(FS_R * $cos(2.0 * PI * real'(ph) / 4096.0)), STOL);
            end
        end

        // Exact latency of a single input change
        apply(a, 0, 12'h000);
        step(15);
        apply(a, 0, 12'h400);
        step(LAT - 1);
        check("lat_before_y", longint'(bus.o_yval), 0, TOL);
        step(1);
        check("lat_at_y", longint'(bus.o_yval), FS, TOL);

        // Enable low for 5 cycles freezes outputs and stretches latency by 5
        apply(a, 0, 12'h000);
        step(1);
        bus.enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("hold_y", longint'(bus.o_yval), FS, TOL);
            check("hold_x", longint'(bus.o_xval), 0, TOL);
        end
        bus.enable = 1'b1;
        step(LAT - 2);
        check("en_before_y", longint'(bus.o_yval), FS, TOL);
        step(1);
        check("en_at_y", longint'(bus.o_yval), 0, TOL);
        check("en_at_x", longint'(bus.o_xval), FS, TOL);

        // Asynchronous reset mid-stream, then first-output latency after release
        apply(a, 0, 12'h200);
        step(15);
        check("pre_rst_x", longint'(bus.o_xval), H, TOL);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_x", longint'(bus.o_xval), 0, 0);
        check("rst_async_y", longint'(bus.o_yval), 0, 0);
        apply(0, 0, 12'h000);
        step(2);
        reset_n = 1'b1;
        step(3);
        check("rst_idle_x", longint'(bus.o_xval), 0, 0);
        apply(a, 0, 12'h000);
        step(LAT - 1);
        check("rst_before_x", longint'(bus.o_xval), 0, 0);
        step(1);
        check("rst_first_x", longint'(bus.o_xval), FS, TOL);
        check("rst_first_y", longint'(bus.o_yval), 0, TOL);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
